// File: rtl/hbram_pkg.sv
// Shared types and widths for the HyperRAM command arbiter.
package hbram_pkg;

  localparam int ADDR_W = 32;
  localparam int LEN_W  = 11;

  typedef enum logic [2:0] {
    ST_WAIT_CAL  = 3'd0,
    ST_IDLE      = 3'd1,
    ST_ISSUE     = 3'd2,
    ST_WAIT_BUSY = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } arb_state_e;

  // A burst is legal when it moves at least one word and no more than max_burst.
  function automatic logic len_legal(input logic [LEN_W-1:0] len, input int max_burst);
    return (len != '0) && (int'(len) <= max_burst);
  endfunction

endpackage

// File: rtl/hbram_cmd_arbiter_rr.sv
// Combinational round-robin picker: first requester at or after the pointer.
module rr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output logic [IDX_W-1:0]     idx_o
);

  // Scan the request vector starting at the pointer, wrapping past the last port.
  always_comb begin
    int   pos;
    logic found;
    // NOTE: every output gets a default before the loop so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      pos = (int'(ptr_i) + k) % NUM_PORTS;
      if (!found && req_i[pos]) begin
        found      = 1'b1;
        gnt_o[pos] = 1'b1;
        idx_o      = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/hbram_cmd_arbiter.sv
// Arbitrates NUM_PORTS command requesters onto one HyperRAM native command port.
module hbram_cmd_arbiter
  import hbram_pkg::*;
#(
  parameter int NUM_PORTS    = 4,
  parameter int MAX_BURST    = 128,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic                          ram_clock,
  input  logic                          ram_reset,
  input  logic [NUM_PORTS-1:0]          port_req,
  input  logic [NUM_PORTS-1:0]          port_rw,
  input  logic [NUM_PORTS*ADDR_W-1:0]   port_addr,
  input  logic [NUM_PORTS*LEN_W-1:0]    port_len,
  output logic [NUM_PORTS-1:0]          port_ack,
  output logic [NUM_PORTS-1:0]          port_done,
  output logic [NUM_PORTS-1:0]          port_err,
  input  logic                          hbc_cal_pass,
  input  logic                          native_ctrl_idle,
  output logic                          native_ram_en,
  output logic                          native_rw_ctrl,
  output logic [ADDR_W-1:0]             native_ram_address,
  output logic [LEN_W-1:0]              native_ram_burst_len,
  output logic [$clog2(NUM_PORTS)-1:0]  grant_id,
  output logic                          arb_busy
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  arb_state_e             state_q, state_d, back_st;
  logic [IDX_W-1:0]       rr_q, rr_d, grant_q, grant_d, rr_next, sel_idx;
  logic                   rw_q, rw_d, reject_q, reject_d, cal_lost_q, cal_lost_d;
  logic [ADDR_W-1:0]      addr_q, addr_d, sel_addr;
  logic [LEN_W-1:0]       len_q, len_d, sel_len;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   en_q, en_d, busy_q, sel_ok;
  logic [NUM_PORTS-1:0]   ack_q, ack_d, done_q, done_d, err_q, err_d;
  logic [NUM_PORTS-1:0]   sel_gnt, grant_oh;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS), .IDX_W(IDX_W)) u_rr (
    .req_i (port_req),
    .ptr_i (rr_q),
    .gnt_o (sel_gnt),
    .idx_o (sel_idx)
  );

  assign sel_addr = port_addr[sel_idx*ADDR_W +: ADDR_W];
  assign sel_len  = port_len[sel_idx*LEN_W +: LEN_W];
  assign sel_ok   = len_legal(sel_len, MAX_BURST);
  assign grant_oh = NUM_PORTS'(1) << grant_q;
  assign rr_next  = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + IDX_W'(1);
  // A transfer that saw calibration drop finishes, then parks in WAIT_CAL.
  assign back_st  = (cal_lost_q || !hbc_cal_pass) ? ST_WAIT_CAL : ST_IDLE;

  // Next-state and registered-output decode; pulses are computed one cycle
  // ahead so they land in the same cycle as the state they belong to.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    grant_d    = grant_q;
    rw_d       = rw_q;
    addr_d     = addr_q;
    len_d      = len_q;
    reject_d   = reject_q;
    cnt_d      = cnt_q;
    cal_lost_d = cal_lost_q | ~hbc_cal_pass;
    en_d       = 1'b0;
    ack_d      = '0;
    done_d     = '0;
    err_d      = '0;
    unique case (state_q)
      ST_WAIT_CAL: begin
        if (hbc_cal_pass && native_ctrl_idle) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (back_st == ST_WAIT_CAL) begin
          state_d = ST_WAIT_CAL;
        end else if (|port_req) begin
          grant_d  = sel_idx;
          rw_d     = port_rw[sel_idx];
          addr_d   = sel_addr;
          len_d    = sel_len;
          reject_d = ~sel_ok;
          en_d     = sel_ok;
          ack_d    = sel_gnt;
          err_d    = sel_ok ? '0 : sel_gnt;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (reject_q) begin
          rr_d    = rr_next;
          state_d = back_st;
        end else begin
          // Counts cycles since native_ram_en, so a timeout lands exactly
          // BUSY_TIMEOUT cycles after the command pulse.
          cnt_d   = CNT_W'(1);
          state_d = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!native_ctrl_idle) begin
          state_d = ST_WAIT_IDLE;
        end else if (cnt_q >= CNT_W'(BUSY_TIMEOUT - 1)) begin
          done_d  = grant_oh;
          err_d   = grant_oh;
          rr_d    = rr_next;
          state_d = back_st;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_WAIT_IDLE: begin
        if (native_ctrl_idle) begin
          done_d  = grant_oh;
          rr_d    = rr_next;
          state_d = back_st;
        end
      end
      default: state_d = ST_WAIT_CAL;
    endcase
    if (state_d == ST_WAIT_CAL) cal_lost_d = 1'b0;
  end

  // State and output registers with synchronous reset; reset drops any
  // in-flight transfer without a done or err pulse.
  always_ff @(posedge ram_clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (ram_reset) begin
      state_q    <= ST_WAIT_CAL;
      rr_q       <= '0;
      grant_q    <= '0;
      rw_q       <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      reject_q   <= 1'b0;
      cnt_q      <= '0;
      cal_lost_q <= 1'b0;
      en_q       <= 1'b0;
      ack_q      <= '0;
      done_q     <= '0;
      err_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      grant_q    <= grant_d;
      rw_q       <= rw_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      reject_q   <= reject_d;
      cnt_q      <= cnt_d;
      cal_lost_q <= cal_lost_d;
      en_q       <= en_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      err_q      <= err_d;
      busy_q     <= (state_d != ST_IDLE);
    end
  end

  assign port_ack             = ack_q;
  assign port_done            = done_q;
  assign port_err             = err_q;
  assign native_ram_en        = en_q;
  assign native_rw_ctrl       = rw_q;
  assign native_ram_address   = addr_q;
  assign native_ram_burst_len = len_q;
  assign grant_id             = grant_q;
  assign arb_busy             = busy_q;

endmodule
